// File: rtl/bias_relu_pkg.sv
// Shared constants, layer codes and per-element arithmetic for the bias/ReLU stage.
// Bias ROM contents are a constant table here rather than a loaded memory file.
package bias_relu_pkg;

    localparam int unsigned DATA_LEN   = 8;
    localparam int unsigned BIAS_BANK  = 32;
    localparam int unsigned BIAS_DEPTH = 160;
    localparam int unsigned NUM_CH     = 32;
    localparam int unsigned NUM_POS    = 12;
    localparam int unsigned BLOCK_W    = NUM_CH * NUM_POS * DATA_LEN;

    typedef enum logic [3:0] {
        LAYER0 = 4'd0,
        LAYER1 = 4'd1,
        LAYER2 = 4'd2,
        LAYER3 = 4'd3,
        AFFINE = 4'd4
    } layer_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_RUN,
        ST_DONE
    } state_e;

    function automatic logic layer_legal(input logic [3:0] l);
        logic ok;
        ok = 1'b0;
        case (l)
            LAYER0, LAYER1, LAYER2, LAYER3, AFFINE: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [7:0] bank_base(input logic [3:0] l);
        logic [7:0] b;
        b = '0;
        case (l)
            LAYER0:  b = 8'(0 * BIAS_BANK);
            LAYER1:  b = 8'(1 * BIAS_BANK);
            LAYER2:  b = 8'(2 * BIAS_BANK);
            LAYER3:  b = 8'(3 * BIAS_BANK);
            AFFINE:  b = 8'(4 * BIAS_BANK);
            default: b = '0;
        endcase
        return b;
    endfunction

    // Sum is one bit wider than the data, so overflow shows as the top two bits differing.
    function automatic logic [DATA_LEN-1:0] post_op(
        input logic [DATA_LEN-1:0] x,
        input logic [DATA_LEN-1:0] b,
        input logic                relu_en
    );
        logic [DATA_LEN:0]   s;
        logic [DATA_LEN-1:0] r;
        s = {x[DATA_LEN-1], x} + {b[DATA_LEN-1], b};
        if (relu_en && s[DATA_LEN])
            r = '0;
        else if (!s[DATA_LEN] && s[DATA_LEN-1])
            r = {1'b0, {(DATA_LEN-1){1'b1}}};
        else if (s[DATA_LEN] && !s[DATA_LEN-1])
            r = {1'b1, {(DATA_LEN-1){1'b0}}};
        else
            r = s[DATA_LEN-1:0];
        return r;
    endfunction

    function automatic logic [DATA_LEN-1:0] bias_table(input logic [7:0] addr);
        int unsigned         a;
        int unsigned         k;
        logic [DATA_LEN-1:0] v;
        a = 32'(addr);
        k = a % BIAS_BANK;
        v = '0;
        if (a < BIAS_BANK) begin
            if (k == 0)
                v = DATA_LEN'(20);
            else if (k == 1)
                v = DATA_LEN'(30);
        end else if (a < 2 * BIAS_BANK) begin
            v = DATA_LEN'(k);
        end else if (a < 3 * BIAS_BANK) begin
            v = DATA_LEN'(5);
        end else if (a < 4 * BIAS_BANK) begin
            v = DATA_LEN'(-5);
        end else if (a < BIAS_DEPTH) begin
            if (k == 0)
                v = DATA_LEN'(-20);
            else if (k == 1)
                v = DATA_LEN'(2);
        end
        return v;
    endfunction

endpackage

// File: rtl/bias_relu_rom.sv
// Synchronous bias ROM: address sampled on one edge, data valid after the next.
module bias_rom
    import bias_relu_pkg::*;
(
    input  logic                clk,
    input  logic [7:0]          addr,
    output logic [DATA_LEN-1:0] q
);

    always_ff @(posedge clk) begin
        q <= bias_table(addr);
    end

endmodule

// File: rtl/bias_relu.sv
// Bias add, ReLU and saturation over a captured 32x12 partial-sum block,
// one channel per cycle with all 12 positions in parallel.
module bias_relu
    import bias_relu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [3:0]         cs_layer,
    input  logic               valid_in,
    input  logic [BLOCK_W-1:0] d,
    output logic               valid,
    output logic [BLOCK_W-1:0] q
);

    state_e                      state;
    state_e                      state_nx;
    logic [4:0]                  ch;
    logic [7:0]                  rom_addr;
    logic [3:0]                  layer_r;
    logic [BLOCK_W-1:0]          d_buf;
    logic [DATA_LEN-1:0]         romout;
    logic [NUM_POS*DATA_LEN-1:0] lane_res;
    logic                        relu_en;
    logic                        start;

    bias_rom u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .q    (romout)
    );

    assign relu_en = (layer_r != AFFINE);
    assign start   = load && valid_in && layer_legal(cs_layer);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (!load) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (start) state_nx = ST_CAPTURE;
                ST_CAPTURE: state_nx = ST_RUN;
                ST_RUN:     if (ch == 5'd31) state_nx = ST_DONE;
                ST_DONE:    state_nx = ST_DONE;
                default:    state_nx = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        lane_res = '0;
        for (int unsigned j = 0; j < NUM_POS; j++) begin
            lane_res[j*DATA_LEN +: DATA_LEN] =
                post_op(d_buf[(NUM_POS * 32'(ch) + j) * DATA_LEN +: DATA_LEN], romout, relu_en);
        end
    end

    // rom_addr runs one channel ahead of ch so romout lines up with the lanes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            q        <= '0;
            d_buf    <= '0;
            ch       <= '0;
            rom_addr <= '0;
            layer_r  <= '0;
        end else if (!load) begin
            valid <= 1'b0;
            ch    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        d_buf    <= d;
                        layer_r  <= cs_layer;
                        rom_addr <= bank_base(cs_layer);
                        ch       <= '0;
                    end
                end
                ST_CAPTURE: begin
                    rom_addr <= rom_addr + 8'd1;
                end
                ST_RUN: begin
                    for (int unsigned j = 0; j < NUM_POS; j++) begin
                        q[(NUM_POS * 32'(ch) + j) * DATA_LEN +: DATA_LEN] <=
                            lane_res[j*DATA_LEN +: DATA_LEN];
                    end
                    rom_addr <= rom_addr + 8'd1;
                    ch       <= ch + 5'd1;
                    if (ch == 5'd31)
                        valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bias_relu.sv
// Self-checking bench for bias_relu: table-driven full runs with a block scoreboard,
// plus abort, mid-run reset and illegal-layer sequences.
module tb_bias_relu;
    import bias_relu_pkg::*;

    logic               clk;
    logic               rst_n;
    logic               load;
    logic [3:0]         cs_layer;
    logic               valid_in;
    logic [BLOCK_W-1:0] d;
    logic               valid;
    logic [BLOCK_W-1:0] q;

    int n_cmp;
    int n_fail;

    logic [BLOCK_W-1:0] sb[$];
    logic [BLOCK_W-1:0] q_model;

    typedef struct {
        logic [3:0] layer;
        logic [7:0] dval;
        bit         rnd;
        bit         perturb;
        int         spot_ch;
        logic [7:0] spot_exp;
        string      name;
    } vec_t;

    vec_t vecs[11];

    bias_relu dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .cs_layer (cs_layer),
        .valid_in (valid_in),
        .d        (d),
        .valid    (valid),
        .q        (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] ref_bias(input int a);
        int k;
        k = a % 32;
        if (a < 32)  return (k == 0) ? 8'd20 : (k == 1) ? 8'd30 : 8'd0;
        if (a < 64)  return 8'(k);
        if (a < 96)  return 8'd5;
        if (a < 128) return 8'hFB;
        if (a < 160) return (k == 0) ? 8'hEC : (k == 1) ? 8'd2 : 8'd0;
        return 8'd0;
    endfunction

    function automatic logic [7:0] ref_elem(input logic [3:0] layer, input logic [7:0] x,
                                            input logic [7:0] b);
        int s;
        s = int'($signed(x)) + int'($signed(b));
        if (layer != 4'd4 && s < 0) return 8'd0;
        if (s > 127)  return 8'h7F;
        if (s < -128) return 8'h80;
        return 8'(s);
    endfunction

    function automatic logic [BLOCK_W-1:0] expected_block(input logic [3:0] layer,
                                                          input logic [BLOCK_W-1:0] din);
        logic [BLOCK_W-1:0] r;
        int base;
        base = (layer == 4'd4) ? 128 : 32 * int'(layer);
        r = '0;
        for (int c = 0; c < 32; c++)
            for (int p = 0; p < 12; p++)
                r[(12*c+p)*8 +: 8] = ref_elem(layer, din[(12*c+p)*8 +: 8], ref_bias(base + c));
        return r;
    endfunction

    function automatic logic [BLOCK_W-1:0] fill_block(input logic [7:0] v, input bit rnd);
        logic [BLOCK_W-1:0] r;
        for (int i = 0; i < 384; i++)
            r[i*8 +: 8] = rnd ? 8'($urandom) : v;
        return r;
    endfunction

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_block(input string name, input logic [BLOCK_W-1:0] exp);
        int bad;
        bad = -1;
        for (int i = 0; i < 384; i++)
            if (bad < 0 && q[i*8 +: 8] !== exp[i*8 +: 8]) bad = i;
        n_cmp++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s: ch %0d pos %0d got %h, expected %h", name, bad / 12, bad % 12,
                     q[bad*8 +: 8], exp[bad*8 +: 8]);
        end
    endtask

    task automatic full_run(input logic [3:0] layer, input logic [BLOCK_W-1:0] din,
                            input bit perturb, input int spot_ch, input logic [7:0] spot_exp,
                            input string name);
        logic [BLOCK_W-1:0] exp_blk;
        int lat;
        @(negedge clk);
        load     = 1'b1;
        valid_in = 1'b1;
        cs_layer = layer;
        d        = din;
        sb.push_back(expected_block(layer, din));
        lat = -1;
        for (int n = 0; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (perturb && n == 3) begin
                d        = ~din;
                cs_layer = (layer == 4'd4) ? 4'd0 : 4'd4;
                valid_in = 1'b0;
            end
            if (valid === 1'b1) begin
                lat = n;
                break;
            end
        end
        check_int({name, " latency"}, lat, 33);
        exp_blk = sb.pop_front();
        check_block({name, " block"}, exp_blk);
        q_model = exp_blk;
        if (spot_ch >= 0)
            check_int({name, " spot"}, int'(q[(12*spot_ch+7)*8 +: 8]), int'(spot_exp));
        repeat (3) @(negedge clk);
        check_int({name, " valid hold"}, int'(valid === 1'b1), 1);
        load     = 1'b0;
        valid_in = 1'b0;
        @(negedge clk);
        check_int({name, " valid fall"}, int'(valid === 1'b1), 0);
    endtask

    initial begin
        logic [BLOCK_W-1:0] din;
        logic [BLOCK_W-1:0] exp_blk;
        int vhigh;

        n_cmp  = 0;
        n_fail = 0;
        rst_n    = 1'b0;
        load     = 1'b0;
        valid_in = 1'b0;
        cs_layer = 4'd0;
        d        = '0;
        q_model  = '0;

        vecs[0]  = '{4'd1, 8'd10,  1'b0, 1'b0, 0,  8'd10, "l1_ch0"};
        vecs[1]  = '{4'd1, 8'd10,  1'b0, 1'b0, 5,  8'd15, "l1_ch5"};
        vecs[2]  = '{4'd0, 8'hCE,  1'b0, 1'b0, 0,  8'd0,  "l0_relu"};
        vecs[3]  = '{4'd0, 8'd120, 1'b0, 1'b0, 1,  8'h7F, "l0_sat"};
        vecs[4]  = '{4'd4, 8'h88,  1'b0, 1'b0, 0,  8'h80, "aff_negsat"};
        vecs[5]  = '{4'd4, 8'hFB,  1'b0, 1'b0, 1,  8'hFD, "aff_neg"};
        vecs[6]  = '{4'd3, 8'd3,   1'b0, 1'b0, 4,  8'd0,  "l3_relu"};
        vecs[7]  = '{4'd2, 8'hFD,  1'b0, 1'b0, 9,  8'd2,  "l2_small"};
        vecs[8]  = '{4'd4, 8'd3,   1'b0, 1'b0, 2,  8'd3,  "aff_pos"};
        vecs[9]  = '{4'd2, 8'd0,   1'b1, 1'b1, -1, 8'd0,  "l2_rnd_perturb"};
        vecs[10] = '{4'd4, 8'd0,   1'b1, 1'b0, -1, 8'd0,  "aff_rnd"};

        repeat (3) @(negedge clk);
        check_int("reset valid", int'(valid === 1'b1), 0);
        check_int("reset q", int'(q === '0), 1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++)
            full_run(vecs[i].layer, fill_block(vecs[i].dval, vecs[i].rnd), vecs[i].perturb,
                     vecs[i].spot_ch, vecs[i].spot_exp, vecs[i].name);

        // Abort: load sampled low at E10 after channels 0..7 were written.
        din = fill_block(8'd10, 1'b0);
        exp_blk = expected_block(4'd1, din);
        @(negedge clk);
        load     = 1'b1;
        valid_in = 1'b1;
        cs_layer = 4'd1;
        d        = din;
        vhigh    = 0;
        for (int n = 0; n <= 9; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid !== 1'b0) vhigh++;
        end
        load     = 1'b0;
        valid_in = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (valid !== 1'b0) vhigh++;
        end
        check_int("abort valid", vhigh, 0);
        for (int c = 0; c < 8; c++)
            q_model[c*96 +: 96] = exp_blk[c*96 +: 96];
        check_block("abort partial q", q_model);

        full_run(4'd1, din, 1'b0, 31, 8'd41, "after_abort");

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        load     = 1'b1;
        valid_in = 1'b1;
        cs_layer = 4'd0;
        d        = fill_block(8'd0, 1'b1);
        for (int n = 0; n <= 20; n++) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_int("midrun reset valid", int'(valid === 1'b1), 0);
        check_int("midrun reset q", int'(q === '0), 1);
        q_model = '0;
        @(negedge clk);
        load     = 1'b0;
        valid_in = 1'b0;
        rst_n    = 1'b1;

        // Illegal layer code never captures.
        @(negedge clk);
        load     = 1'b1;
        valid_in = 1'b1;
        cs_layer = 4'hF;
        d        = fill_block(8'd0, 1'b1);
        vhigh    = 0;
        repeat (50) begin
            @(negedge clk);
            if (valid !== 1'b0) vhigh++;
        end
        check_int("illegal layer valid", vhigh, 0);
        check_block("illegal layer q", q_model);
        load     = 1'b0;
        valid_in = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bias_relu.md
# bias_relu

Post-processing stage directly downstream of `dot`. It captures the 32-channel × 12-position partial-sum block when `dot` raises `valid`. It adds a per-channel bias fetched from a bias ROM indexed by the active layer, applies ReLU (conv layers only), and saturates back to `` `data_len ``. The finished block is presented to the next layer stage with its own `valid`.

## Interface
- Parameters: none. Data width comes from `` `data_len `` (num_data.v). Layer codes come from `` `LAYER0..`LAYER3 ``, `` `AFFINE `` (state_layer_data.v).
- Reset is asynchronous, active-low; one clock.
- `clk` — in — 1 — system clock.
- `rst_n` — in — 1 — asynchronous active-low reset.
- `load` — in — 1 — same layer-run enable that drives `dot`; low aborts and returns to idle.
- `cs_layer` — in — 4 — current layer code; selects bias bank and ReLU enable.
- `valid_in` — in — 1 — `dot` valid; held high until `load` falls.
- `d` — in — 32·12·`` `data_len `` — `dot` output; element (ch i, pos j) at index 12·i+j, signed two's complement.
- `valid` — out — 1 — result block complete; held until `load` falls.
- `q` — out — 32·12·`` `data_len `` — processed block, same element layout as `d`.

## Operation
- FSM states and transitions:
  - IDLE → CAPTURE on the first edge with `load`=1, `valid_in`=1 and a legal `cs_layer`. At that edge `d` is copied into the input buffer, `cs_layer` is latched, and `rom_addr` = base.
  - CAPTURE → RUN unconditionally; `rom_addr` = base+1.
  - RUN processes one channel per cycle, all 12 lanes in parallel. It uses `romout` for that channel while addressing the next one.
  - RUN → DONE after channel 31.
  - DONE holds while `load`=1.
- Bank base: LAYER0..3 → 0/32/64/96; AFFINE → 128. The bias ROM holds 160 entries, 8-bit address.
- Illegal `cs_layer` in IDLE: stay IDLE, never assert `valid`.
- Per element: s = sext(d) + sext(bias), computed at `` `data_len ``+1 bits.
  - LAYER0..3: if s<0 the result is 0, else min(s, max_pos).
  - AFFINE: saturate s to [min_neg, max_pos]; no ReLU.
- `valid_in` is ignored outside IDLE.
- `cs_layer` changes after capture are ignored.
- `load`=0 in any state → IDLE at the next edge, `valid`=0.
  - Channels already written keep their new values; the rest keep their prior values.
  - A new run needs `valid_in` to be sampled high again in IDLE.

## Timing
- E0 = capture edge. Channel k result is written to `q` at edge E(k+2).
- `valid` rises at E33, the same edge as the channel-31 write. Latency from E0 is 33 cycles.
- Bias ROM is synchronous, one-cycle read latency: address registered at edge n, `romout` valid after edge n+1.
- `valid` falls at the first edge with `load`=0.
- Reset values: `valid`=0, `q`=0, input buffer=0, state=IDLE, channel counter=0, `rom_addr`=0.
- Reset mid-run clears everything asynchronously; no output glitch beyond the reset values.

## Structure
- Shared headers:
  - num_data.v keeps `` `data_len ``.
  - state_layer_data.v keeps the layer codes.
  - Add `` `BIAS_BANK `` (32) and `` `BIAS_DEPTH `` (160) to num_data.v.
- One sub-module, `bias_rom`: ports clk, addr[7:0], q[`` `data_len ``-1:0]; contents from a `$readmemb` file, same style as `rom`.
- Top: FSM, channel counter (5 bits), input buffer, 12 lanes of add/ReLU/saturate, output register.

## Test plan
All cases use `data_len`=8.
- LAYER1 run:
  - Stimulus: all d=10, bias[32+k]=k.
  - Response: `valid` at E0+33; element (ch k, any pos) = 10+k.
  - Response: `valid` stays high until `load` falls, then drops on the next edge.
- ReLU and saturation in LAYER0:
  - Stimulus d=-50 with bias[0]=20 → 0.
  - Stimulus d=120 with bias[1]=30 → 127.
- AFFINE:
  - Stimulus d=-120, bias[128]=-20 → -128 (no ReLU).
  - Stimulus d=-5, bias[129]=2 → -3.
- Abort: `load` drops at E10.
  - Response: `valid` never rises; state is IDLE at E11.
  - Response: `q` channels 0–7 are updated, channels 8–31 keep their previous values.
  - Response: a following full run completes normally.
- Reset: `rst_n` pulsed low at E20 → `q`=0 and `valid`=0 immediately. Illegal `cs_layer`=4'hF with `valid_in`=1 → no capture and no `valid` over 50 cycles.
